rol32_rotator: RTL and testbench
================================

Name: rol32_rotator

Overview:
- 32-bit rotate-left unit for the CPU datapath ALU (ROL instruction).
- Rotates operand `in_data` left by `num_rotate` bit positions, modulo 32.
- Result is registered: one clock of latency, with a valid flag alongside it.
- Sits beside the shift units and feeds the ALU result mux.

Parameters:
- DATA_W, 32, operand/result width; must be a power of two; the 32 default is the only supported configuration.
- CNT_W, 32, width of the `num_rotate` port (the full register-file word).
- SHAMT_W, $clog2(DATA_W) = 5, effective rotate-amount bits; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-high reset
- in_valid  input  1  operands valid this cycle
- in_data  input  DATA_W  operand to rotate
- num_rotate  input  CNT_W  rotate amount; only bits [SHAMT_W-1:0] are used
- out_data  output  DATA_W  registered rotated result
- out_valid  output  1  out_data holds a fresh result
- out_zero  output  1  registered flag: out_data == 0

Behaviour:
- Function:
  - Let amt = num_rotate[4:0].
  - result[i] = in_data[(i - amt) mod 32] for i = 0..31.
  - Equivalent to (in_data << amt) | (in_data >> (32 - amt)), with amt = 0 meaning pass-through.
- num_rotate[CNT_W-1:5] is ignored, so amounts 32, 64, ... rotate by 0.
- Timing:
  - On each rising clk with clr = 0 and in_valid = 1: out_data <= result, out_zero <= (result == 0), out_valid <= 1.
  - With in_valid = 0: out_data and out_zero hold; out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is 1 operation per cycle with no stall and no back-pressure.
- Reset:
  - clr = 1 at a rising edge forces out_data = 0, out_zero = 1, out_valid = 0.
  - clr has priority over in_valid, so an operation presented in the reset cycle is discarded.
  - clr is synchronous: outputs do not change until the edge.
- Rotation datapath:
  - Combinational five-stage barrel: stage k rotates by 2^k when amt[k] = 1.
  - No loss of bits: popcount(out_data) == popcount(in_data).
- X handling: none required. Inputs are assumed 2-state when in_valid = 1.

Optional Feature:
- Macro: ROL32_ROR_EN.
- Defined:
  - Adds input port `dir` (1 bit).
  - dir = 1 selects rotate-right by amt: result[i] = in_data[(i + amt) mod 32].
  - Implemented as a left rotate by (32 - amt) mod 32.
  - dir = 0 is identical to rotate-left.
  - Latency and flags are unchanged.
- Undefined: no `dir` port; rotate-left only.

Decomposition:
- Package `rol32_pkg` holds:
  - localparam DATA_W = 32 and SHAMT_W = 5.
  - typedef `word_t` (logic [31:0]) and `shamt_t` (logic [4:0]).
  - function `rotl(word_t, shamt_t)` as the golden model shared with the bench.
- One sub-module, `rol32_barrel`: purely combinational five-stage rotator (word_t in, shamt_t amt → word_t out).
  - Under ROL32_ROR_EN it also takes `dir`.
- The top level adds the amount truncation, output registers, valid and zero flags.

Test Plan:
- Basic rotate: clr 2 cycles, then in_data = 0x00000001, num_rotate = 1, in_valid = 1 → next cycle out_data = 0x00000002, out_valid = 1, out_zero = 0.
- Wrap-around: in_data = 0x00400000, num_rotate = 30 → out_data = 0x00100000; in_data = 0x80000001, num_rotate = 4 → 0x00000018.
- Amount boundaries:
  - in_data = 0xDEADBEEF with num_rotate = 0, 32 and 0xFFFFFFE0 → out_data = 0xDEADBEEF each time.
  - num_rotate = 31 → 0xEF56DF77.
- Back-to-back plus zero flag:
  - Consecutive-cycle ops (0x12345678, 8) then (0x00000000, 5) → 0x34567812 with out_zero = 0, then 0x00000000 with out_zero = 1.
  - Then in_valid = 0 → out_valid = 0, data held.
- Reset mid-operation: in_valid = 1 and clr = 1 in the same cycle → out_data = 0, out_valid = 0, out_zero = 1; the next valid op (0x1, 1) produces 0x2.
- Random sweep: 10k random (in_data, num_rotate) pairs checked against `rotl()` and popcount preservation; under ROL32_ROR_EN also check dir = 1 (in_data = 0x00000001, amt = 1 → 0x80000000).

Source files
------------

// File: rtl/rol32_pkg.sv
// Shared definitions for the 32-bit rotate-left unit.
// Holds the word/amount types and a reference rotate function that serves as
// the behavioural model for the rotator.
// Optional feature macro: ROL32_ROR_EN (adds rotate-right; see rol32_rotator).
package rol32_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [SHAMT_W-1:0] shamt_t;

    // Rotate left by amt; amt == 0 is a pass-through (avoids a 32-bit shift).
    function automatic word_t rotl(input word_t data, input shamt_t amt);
        word_t res;
        if (amt == '0) begin
            res = data;
        end else begin
            res = (data << amt) | (data >> (6'd32 - {1'b0, amt}));
        end
        return res;
    endfunction

endpackage

// File: rtl/rol32_barrel.sv
// Purely combinational five-stage barrel rotator.
// Stage k rotates the running word left by 2^k when amt[k] is set.
// Ports:
//   data_in  - operand
//   amt      - rotate amount (5 bits)
//   dir      - (only with ROL32_ROR_EN) 1 = rotate right, 0 = rotate left
//   data_out - rotated operand
module rol32_barrel
    import rol32_pkg::*;
(
    input  word_t  data_in,
    input  shamt_t amt,
`ifdef ROL32_ROR_EN
    input  logic   dir,
`endif
    output word_t  data_out
);

    shamt_t amt_eff;

`ifdef ROL32_ROR_EN
    // Right rotate by amt is a left rotate by (32 - amt) mod 32, i.e. the
    // 5-bit two's complement of amt.
    shamt_t neg_amt;
    assign neg_amt = ~amt + 1'b1;
    assign amt_eff = dir ? neg_amt : amt;
`else
    assign amt_eff = amt;
`endif

    word_t stage [SHAMT_W+1];

    assign stage[0] = data_in;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int unsigned SH = 1 << k;
        assign stage[k+1] = amt_eff[k]
            ? {stage[k][DATA_W-1-SH:0], stage[k][DATA_W-1:DATA_W-SH]}
            : stage[k];
    end

    assign data_out = stage[SHAMT_W];

endmodule

// File: rtl/rol32_rotator.sv
// 32-bit rotate-left unit for the ALU (ROL). One cycle of latency, full
// throughput, no back-pressure.
// Ports:
//   clk        - rising-edge clock
//   clr        - synchronous active-high reset (priority over in_valid)
//   in_valid   - operands valid this cycle
//   in_data    - operand to rotate
//   num_rotate - rotate amount; only bits [4:0] are used
//   dir        - (only with ROL32_ROR_EN) 1 = rotate right
//   out_data   - registered result
//   out_valid  - out_data holds a fresh result
//   out_zero   - registered flag, out_data == 0
// Optional feature macro: ROL32_ROR_EN.
module rol32_rotator #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  num_rotate,
`ifdef ROL32_ROR_EN
    input  logic              dir,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_zero
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);

    import rol32_pkg::*;

    shamt_t amt;
    word_t  result;
    logic   unused_amt_hi;

    // Upper amount bits are don't-care: rotation is modulo 32.
    assign amt           = num_rotate[SHAMT_W-1:0];
    assign unused_amt_hi = ^num_rotate[CNT_W-1:SHAMT_W];

    rol32_barrel u_barrel (
        .data_in  (in_data),
        .amt      (amt),
`ifdef ROL32_ROR_EN
        .dir      (dir),
`endif
        .data_out (result)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            out_data  <= '0;
            out_zero  <= 1'b1;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            out_data  <= result;
            out_zero  <= (result == '0);
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rol32_rotator.sv
module tb_rol32_rotator;
    import rol32_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] num_rotate;
`ifdef ROL32_ROR_EN
    logic        dir;
`endif
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_zero;

    int unsigned checks = 0;
    int unsigned errors = 0;

    rol32_rotator #(.DATA_W(32), .CNT_W(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .num_rotate (num_rotate),
`ifdef ROL32_ROR_EN
        .dir        (dir),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] d, input logic [31:0] n);
        in_valid   = 1'b1;
        in_data    = d;
        num_rotate = n;
        tick();
    endtask

    logic [31:0] rd;
    logic [31:0] rn;
    logic [31:0] exp_w;
    logic [31:0] mdl;

    initial begin
        clr = 1'b1; in_valid = 1'b0; in_data = '0; num_rotate = '0;
`ifdef ROL32_ROR_EN
        dir = 1'b0;
`endif
        tick(); tick();
        check("rst_data",  out_data,  32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_zero",  {31'b0, out_zero},  32'h1);
        clr = 1'b0;

        op(32'h0000_0001, 32'd1);
        check("basic_data",  out_data, 32'h0000_0002);
        check("basic_valid", {31'b0, out_valid}, 32'h1);
        check("basic_zero",  {31'b0, out_zero},  32'h0);

        op(32'h0040_0000, 32'd30);
        check("wrap30", out_data, 32'h0010_0000);
        op(32'h8000_0001, 32'd4);
        check("wrap4", out_data, 32'h0000_0018);

        op(32'hDEAD_BEEF, 32'd0);
        check("amt0", out_data, 32'hDEAD_BEEF);
        op(32'hDEAD_BEEF, 32'd32);
        check("amt32", out_data, 32'hDEAD_BEEF);
        op(32'hDEAD_BEEF, 32'hFFFF_FFE0);
        check("amt_hi", out_data, 32'hDEAD_BEEF);
        op(32'hDEAD_BEEF, 32'd31);
        check("amt31", out_data, 32'hEF56_DF77);

        op(32'h1234_5678, 32'd8);
        check("b2b0_data", out_data, 32'h3456_7812);
        check("b2b0_zero", {31'b0, out_zero}, 32'h0);
        op(32'h0000_0000, 32'd5);
        check("b2b1_data", out_data, 32'h0000_0000);
        check("b2b1_zero", {31'b0, out_zero}, 32'h1);
        check("b2b1_valid", {31'b0, out_valid}, 32'h1);

        op(32'h1234_5678, 32'd8);
        in_valid = 1'b0; in_data = 32'hFFFF_FFFF; num_rotate = 32'd3;
        tick();
        check("idle_valid", {31'b0, out_valid}, 32'h0);
        check("idle_data",  out_data, 32'h3456_7812);
        check("idle_zero",  {31'b0, out_zero}, 32'h0);

        // Reset wins over a simultaneous operation.
        clr = 1'b1;
        op(32'hFFFF_FFFF, 32'd1);
        check("clr_data",  out_data, 32'h0);
        check("clr_valid", {31'b0, out_valid}, 32'h0);
        check("clr_zero",  {31'b0, out_zero},  32'h1);
        clr = 1'b0;
        op(32'h0000_0001, 32'd1);
        check("post_clr", out_data, 32'h0000_0002);

`ifdef ROL32_ROR_EN
        dir = 1'b1;
        op(32'h0000_0001, 32'd1);
        check("ror1", out_data, 32'h8000_0000);
        op(32'hDEAD_BEEF, 32'd4);
        check("ror4", out_data, 32'hFDEA_DBEE);
        dir = 1'b0;
`endif

        for (int i = 0; i < 10000; i++) begin
            rd = $urandom();
            rn = $urandom();
`ifdef ROL32_ROR_EN
            dir = 1'($urandom_range(0, 1));
            // Right rotate modelled as left rotate by the negated amount.
            mdl = dir ? rotl(rd, shamt_t'(5'd0 - rn[4:0])) : rotl(rd, rn[4:0]);
`else
            mdl = rotl(rd, rn[4:0]);
`endif
            op(rd, rn);
            check("rand_data", out_data, mdl);
            exp_w = $countones(rd);
            check("rand_popcnt", $countones(out_data), exp_w);
        end

        in_valid = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
